// File: rtl/clk_div_prog.sv
// Runtime-programmable 50%-duty clock divider with registered clk_out/tick outputs and a
// valid/ready divisor load that takes effect only at a full-period boundary.
// Optional phase-restart input `sync` is built only when CLKDIV_SYNC_EN is defined.
module clk_div_prog #(
    parameter int unsigned WIDTH       = 16,
    parameter int unsigned DEFAULT_DIV = 10
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] div_in,
    input  logic             div_valid,
`ifdef CLKDIV_SYNC_EN
    input  logic             sync,
`endif
    output logic             div_ready,
    output logic [WIDTH-1:0] div_active,
    output logic             clk_out,
    output logic             tick
);

    localparam logic [WIDTH-1:0] One     = WIDTH'(1);
    localparam logic [WIDTH-1:0] DivInit = WIDTH'(DEFAULT_DIV);

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] active_q, active_d;
    logic [WIDTH-1:0] shadow_q, shadow_d;
    logic             clk_q, clk_d;
    logic             tick_q, tick_d;
    logic             pend_q, pend_d;
    logic             ready_q, ready_d;

    logic [WIDTH-1:0] eff_div;
    logic             terminal;
    logic             xfer;
    logic             sync_hit;

    // A programmed divisor of zero behaves as one.
    assign eff_div  = (active_q == '0) ? One : active_q;
    assign terminal = (cnt_q == (eff_div - One));
    assign xfer     = div_valid & ready_q;

`ifdef CLKDIV_SYNC_EN
    assign sync_hit = sync;
`else
    assign sync_hit = 1'b0;
`endif

    always_comb begin
        cnt_d    = cnt_q;
        clk_d    = clk_q;
        tick_d   = 1'b0;
        active_d = active_q;
        shadow_d = shadow_q;
        pend_d   = pend_q;
        // Ready lags the pending flag by one cycle on release, drops at once on accept.
        ready_d  = xfer ? 1'b0 : ~pend_q;

        if (sync_hit) begin
            cnt_d = '0;
            clk_d = 1'b0;
            if (pend_q) begin
                active_d = shadow_q;
                pend_d   = 1'b0;
            end
        end else if (en) begin
            if (terminal) begin
                cnt_d  = '0;
                clk_d  = ~clk_q;
                tick_d = ~clk_q;
                // Falling toggle closes a full period: safe point to retune.
                if (clk_q && pend_q) begin
                    active_d = shadow_q;
                    pend_d   = 1'b0;
                end
            end else begin
                cnt_d = cnt_q + One;
            end
        end

        if (xfer) begin
            shadow_d = div_in;
            pend_d   = 1'b1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            cnt_q    <= '0;
            clk_q    <= 1'b0;
            tick_q   <= 1'b0;
            active_q <= DivInit;
            shadow_q <= '0;
            pend_q   <= 1'b0;
            ready_q  <= 1'b1;
        end else begin
            cnt_q    <= cnt_d;
            clk_q    <= clk_d;
            tick_q   <= tick_d;
            active_q <= active_d;
            shadow_q <= shadow_d;
            pend_q   <= pend_d;
            ready_q  <= ready_d;
        end
    end

    assign div_ready  = ready_q;
    assign div_active = active_q;
    assign clk_out    = clk_q;
    assign tick       = tick_q;

endmodule

// File: tb/tb_clk_div_prog.sv
// Self-checking bench for clk_div_prog: a period-position model checked every cycle,
// plus directed scenarios with literal expectations at hand-computed cycles.
module tb_clk_div_prog;

    localparam int unsigned WIDTH = 16;
    localparam int unsigned DEF   = 10;

    logic             clk_in = 1'b0;
    logic             reset = 1'b1;
    logic             en = 1'b0;
    logic [WIDTH-1:0] div_in = '0;
    logic             div_valid = 1'b0;
    logic             sync = 1'b0;
    logic             div_ready;
    logic [WIDTH-1:0] div_active;
    logic             clk_out;
    logic             tick;

    clk_div_prog #(.WIDTH(WIDTH), .DEFAULT_DIV(DEF)) dut (
        .clk_in     (clk_in),
        .reset      (reset),
        .en         (en),
        .div_in     (div_in),
        .div_valid  (div_valid),
`ifdef CLKDIV_SYNC_EN
        .sync       (sync),
`endif
        .div_ready  (div_ready),
        .div_active (div_active),
        .clk_out    (clk_out),
        .tick       (tick)
    );

    always #5 clk_in = ~clk_in;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    bit check_en = 1'b0;

    // Model: t = enabled edges since the current period began; output is high for t in [D, 2D).
    int unsigned      t = 0;
    logic [WIDTH-1:0] m_div = WIDTH'(DEF);
    logic [WIDTH-1:0] m_shadow = '0;
    bit               m_pend = 1'b0;
    bit               m_ready = 1'b1;
    bit               m_tick = 1'b0;
    bit               m_clk = 1'b0;

    function automatic int unsigned eff_of(input logic [WIDTH-1:0] d);
        return (d == '0) ? 1 : int'(d);
    endfunction

    always @(posedge clk_in) begin
        bit xfer;
        bit nready;
        bit sync_v;
        int unsigned eff;
`ifdef CLKDIV_SYNC_EN
        sync_v = sync;
`else
        sync_v = 1'b0;
`endif
        if (reset) begin
            t = 0; m_div = WIDTH'(DEF); m_pend = 0; m_ready = 1; m_tick = 0; m_clk = 0; cyc = 0;
        end else begin
            cyc++;
            xfer   = div_valid && m_ready;
            nready = xfer ? 1'b0 : !m_pend;
            m_tick = 0;
            if (sync_v) begin
                t = 0;
                if (m_pend) begin m_div = m_shadow; m_pend = 0; end
            end else if (en) begin
                eff = eff_of(m_div);
                t++;
                if (t == eff) m_tick = 1;
                if (t == 2 * eff) begin
                    t = 0;
                    if (m_pend) begin m_div = m_shadow; m_pend = 0; end
                end
            end
            if (xfer) begin m_shadow = div_in; m_pend = 1; end
            m_ready = nready;
            m_clk   = (t >= eff_of(m_div));
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, got, exp);
        end
    endtask

    task automatic lit(input string name, input logic [31:0] dutv, input logic [31:0] modv,
                       input logic [31:0] exp);
        chk(name, dutv, exp);
        chk({name, "_model"}, modv, exp);
    endtask

    always @(negedge clk_in) begin
        if (check_en) begin
            chk("clk_out", 32'(clk_out), 32'(m_clk));
            chk("tick", 32'(tick), 32'(m_tick));
            chk("div_ready", 32'(div_ready), 32'(m_ready));
            chk("div_active", 32'(div_active), 32'(m_div));
        end
    end

    task automatic goto(input int n);
        while (cyc < n) @(negedge clk_in);
    endtask

    task automatic reset_seq();
        reset = 1'b1; en = 1'b0; div_valid = 1'b0; sync = 1'b0;
        @(negedge clk_in);
        check_en = 1'b1;
        @(negedge clk_in);
        reset = 1'b0; en = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        // Default divisor: rises at 10 and 30, falls at 20.
        reset_seq();
        lit("rst_clk", 32'(clk_out), 32'(m_clk), 0);
        lit("rst_tick", 32'(tick), 32'(m_tick), 0);
        lit("rst_ready", 32'(div_ready), 32'(m_ready), 1);
        lit("rst_active", 32'(div_active), 32'(m_div), 10);
        goto(9);  lit("d10_c9_clk", 32'(clk_out), 32'(m_clk), 0);
        goto(10); lit("d10_c10_clk", 32'(clk_out), 32'(m_clk), 1);
                  lit("d10_c10_tick", 32'(tick), 32'(m_tick), 1);
        goto(11); lit("d10_c11_tick", 32'(tick), 32'(m_tick), 0);
        goto(20); lit("d10_c20_clk", 32'(clk_out), 32'(m_clk), 0);
        goto(30); lit("d10_c30_tick", 32'(tick), 32'(m_tick), 1);

        // Load 3 at cycle 5: applied at the fall at 20, rises at 23 and 29.
        reset_seq();
        goto(5); div_in = 16'd3; div_valid = 1'b1;
        goto(6); div_valid = 1'b0;
                 lit("ld3_c6_ready", 32'(div_ready), 32'(m_ready), 0);
        goto(10); lit("ld3_c10_tick", 32'(tick), 32'(m_tick), 1);
        goto(20); lit("ld3_c20_active", 32'(div_active), 32'(m_div), 3);
                  lit("ld3_c20_ready", 32'(div_ready), 32'(m_ready), 0);
        goto(21); lit("ld3_c21_ready", 32'(div_ready), 32'(m_ready), 1);
        goto(22); lit("ld3_c22_clk", 32'(clk_out), 32'(m_clk), 0);
        goto(23); lit("ld3_c23_clk", 32'(clk_out), 32'(m_clk), 1);
        goto(26); lit("ld3_c26_clk", 32'(clk_out), 32'(m_clk), 0);
        goto(29); lit("ld3_c29_tick", 32'(tick), 32'(m_tick), 1);

        // Valid held through pending: 4 wins, 7 is taken once ready returns.
        reset_seq();
        goto(2); div_in = 16'd4; div_valid = 1'b1;
        goto(3); div_in = 16'd7;
                 lit("hold_c3_ready", 32'(div_ready), 32'(m_ready), 0);
        goto(19); lit("hold_c19_active", 32'(div_active), 32'(m_div), 10);
        goto(20); lit("hold_c20_active", 32'(div_active), 32'(m_div), 4);
        goto(21); lit("hold_c21_ready", 32'(div_ready), 32'(m_ready), 1);
        goto(22); div_valid = 1'b0;
                  lit("hold_c22_ready", 32'(div_ready), 32'(m_ready), 0);
        goto(24); lit("hold_c24_clk", 32'(clk_out), 32'(m_clk), 1);
        goto(27); lit("hold_c27_active", 32'(div_active), 32'(m_div), 4);
        goto(28); lit("hold_c28_active", 32'(div_active), 32'(m_div), 7);
                  lit("hold_c28_clk", 32'(clk_out), 32'(m_clk), 0);

        // Divisor 0 behaves as 1 but reads back as 0.
        reset_seq();
        goto(1); div_in = 16'd0; div_valid = 1'b1;
        goto(2); div_valid = 1'b0;
        goto(20); lit("d0_c20_active", 32'(div_active), 32'(m_div), 0);
        goto(21); lit("d0_c21_tick", 32'(tick), 32'(m_tick), 1);
        goto(22); lit("d0_c22_clk", 32'(clk_out), 32'(m_clk), 0);
                  lit("d0_c22_tick", 32'(tick), 32'(m_tick), 0);
        goto(23); lit("d0_c23_clk", 32'(clk_out), 32'(m_clk), 1);

        // Enable low for 5 cycles delays the rise to 15; then reset discards a pending load.
        reset_seq();
        goto(3); en = 1'b0;
        goto(8); en = 1'b1;
                 lit("en_c8_tick", 32'(tick), 32'(m_tick), 0);
        goto(14); lit("en_c14_clk", 32'(clk_out), 32'(m_clk), 0);
        goto(15); lit("en_c15_tick", 32'(tick), 32'(m_tick), 1);
        goto(16); div_in = 16'd2; div_valid = 1'b1;
        goto(17); div_valid = 1'b0;
                  lit("en_c17_ready", 32'(div_ready), 32'(m_ready), 0);
                  reset = 1'b1;
        @(negedge clk_in);
        lit("mid_rst_active", 32'(div_active), 32'(m_div), 10);
        lit("mid_rst_ready", 32'(div_ready), 32'(m_ready), 1);
        lit("mid_rst_clk", 32'(clk_out), 32'(m_clk), 0);
        reset = 1'b0;
        repeat (25) @(negedge clk_in);

`ifdef CLKDIV_SYNC_EN
        // Sync at cycle 7 applies the pending 5 and restarts phase: next rise at 13.
        reset_seq();
        goto(2); div_in = 16'd5; div_valid = 1'b1;
        goto(3); div_valid = 1'b0;
        goto(7); sync = 1'b1;
        goto(8); sync = 1'b0;
                 lit("sync_c8_clk", 32'(clk_out), 32'(m_clk), 0);
                 lit("sync_c8_active", 32'(div_active), 32'(m_div), 5);
        goto(9);  lit("sync_c9_ready", 32'(div_ready), 32'(m_ready), 1);
        goto(12); lit("sync_c12_clk", 32'(clk_out), 32'(m_clk), 0);
        goto(13); lit("sync_c13_tick", 32'(tick), 32'(m_tick), 1);
`endif

        check_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/clk_div_prog.md
# clk_div_prog

Runtime-programmable clock divider producing a 50%-duty divided clock and a one-cycle rising-edge tick, both registered in the source clock domain. The divisor is loaded through a valid/ready handshake and takes effect only at a full output-period boundary, so the output never glitches or produces a short half-period. It is the parametrised successor to the fixed-divisor divider and feeds shift-register and peripheral timing logic that needs a retunable rate.

## Interface
- `WIDTH`, 16: width of the divisor and the internal counter.
- `DEFAULT_DIV`, 10: half-period in `clk_in` cycles loaded at reset. Must be ≥1.
- `clk_in`  input  1  source clock; all logic on its rising edge.
- `reset`  input  1  synchronous, active-high reset.
- `en`  input  1  count enable; low freezes the counter and outputs.
- `div_in`  input  WIDTH  requested half-period in `clk_in` cycles.
- `div_valid`  input  1  request to load `div_in`.
- `div_ready`  output  1  high when no update is pending.
- `div_active`  output  WIDTH  half-period currently in use.
- `clk_out`  output  1  divided clock. Period is 2·D cycles, high for D and low for D.
- `tick`  output  1  one-cycle pulse, high in the same cycle `clk_out` first reads 1.
- `sync`  input  1  phase-restart strobe. Present only with `CLKDIV_SYNC_EN`.

## Operation
- Reset values: counter = 0, `clk_out` = 0, `tick` = 0, `div_active` = `DEFAULT_DIV`, `div_ready` = 1, pending flag = 0.
- Effective divisor D = `div_active`. A stored value of 0 is treated as 1; `div_active` still reports 0.
- Counting, when `en` = 1:
  - The counter increments each cycle.
  - At terminal count (counter == D−1), the counter goes to 0 and `clk_out` toggles.
  - If the toggle is 0→1, `tick` = 1 the next cycle; otherwise `tick` = 0.
- When `en` = 0: the counter, `clk_out` and `div_active` hold, and `tick` = 0.
- Handshake:
  - A transfer occurs when `div_valid` and `div_ready` are both high.
  - On transfer, `div_in` is captured into a shadow register, the pending flag sets, and `div_ready` drops the next cycle.
  - `div_valid` while `div_ready` = 0 is ignored. The shadow register is not overwritten.
- Update point: the pending value is copied to `div_active` only at a terminal count where `clk_out` toggles 1→0, i.e. at the end of a full period.
  - The pending flag clears in the same cycle.
  - `div_ready` returns to 1 the following cycle.
- Simultaneous events:
  - If a transfer coincides with the update cycle, the update uses the old shadow value. The new value is not accepted, because `div_ready` was already 0.
  - If `en` = 0 at the update cycle, nothing advances and the update is deferred.
- Reset asserted mid-operation discards any pending value and restores the reset values on the next edge.
- Priority: `reset` > `sync` > `en`.

## Timing
- All outputs are registered; there is no combinational path from inputs to outputs.
- With D constant and `en` = 1, the first `clk_out` rise occurs D cycles after reset deasserts. Rises then repeat every 2·D cycles.
- Divisor update latency: from the accepting edge to the end of the current period, worst case 2·D_old cycles. The new period starts immediately after the update with `clk_out` = 0.
- With D = 1, `clk_out` toggles every cycle and `tick` pulses every 2 cycles.

## Configuration
- `CLKDIV_SYNC_EN` defined: the `sync` port exists. A `sync` = 1 cycle (regardless of `en`) has the following effect on the next edge:
  - counter = 0, `clk_out` = 0, `tick` = 0;
  - any pending shadow value is applied to `div_active` and the pending flag clears.
- `CLKDIV_SYNC_EN` undefined: no `sync` port and no related logic. Phase is set only by `reset`.

## Test plan
- Reset, then `en` = 1 with `DEFAULT_DIV` = 10 → `clk_out` rises at cycle 10, falls at cycle 20, rises at cycle 30; `tick` is high only at cycles 10 and 30.
- Load `div_in` = 3 at cycle 5 → `div_ready` is 0 from cycle 6; `div_active` = 3 after the 1→0 toggle at cycle 20; next rises at cycles 23 and 29; `div_ready` = 1 at cycle 21.
- Hold `div_valid` = 1 with value 4 and then 7 while pending → only 4 is applied; 7 is accepted once `div_ready` returns.
- Load `div_in` = 0 → `clk_out` toggles every cycle and `div_active` reads 0.
- `en` low for 5 cycles mid-half-period → the `clk_out` edge is delayed by exactly 5 cycles and no `tick` fires while `en` is low; assert `reset` while an update is pending → `div_active` = 10 and `div_ready` = 1.
- With `CLKDIV_SYNC_EN`, pulse `sync` at cycle 7 with a pending value of 5 → `clk_out` = 0, `div_active` = 5, and the next rise at cycle 13.
